vx_tcu_bhf_mul_arb: RTL and testbench
=====================================

# vx_tcu_bhf_mul_arb

Shares one FP16×FP16→recoded-FP32 multiplier (`VX_tcu_bhf_fp16mul`) among `NUM_REQS` requesters in the TCU BHF datapath. It round-robin arbitrates valid/ready requests and issues at most one operand pair per cycle into a fixed-latency elastic pipeline around the multiplier. It returns each product on a single response port tagged with requester index and user tag. The block also exports busy status and a stall-cycle counter.

## Interface
- `NUM_REQS`, 4: number of requesters, ≥2.
- `TAG_WIDTH`, 8: user tag width, ≥1.
- `LATENCY`, 2: register stages from accept to `rsp_valid`, ≥1.
- `IDX_W`, `$clog2(NUM_REQS)`: derived localparam.

- `clk`  in  1  clock; all state is updated on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  [NUM_REQS]  per-requester request valid.
- `req_a`, `req_b`  in  [NUM_REQS][16]  FP16 operands.
- `req_tag`  in  [NUM_REQS][TAG_WIDTH]  opaque tag, returned unchanged.
- `req_ready`  out  [NUM_REQS]  one-hot or zero; a request is accepted when valid&&ready.
- `rsp_valid`  out  1  product available.
- `rsp_y`  out  33  recoded FP32 product.
- `rsp_idx`  out  IDX_W  index of the originating requester.
- `rsp_tag`  out  TAG_WIDTH  tag of the originating request.
- `rsp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  at least one stage holds a valid entry.
- `stall_cnt`  out  32  cycles with rsp_valid && !rsp_ready, saturating.

## Operation
- **Advance enable:** `adv = !(rsp_valid && !rsp_ready)`. The pipeline advances globally, so all stages hold together; bubbles do not collapse.
- **Grant:** the first `i` with `req_valid[i]`, scanning cyclically from `rr_ptr` (`rr_ptr`, `rr_ptr+1`, … mod NUM_REQS).
  - `req_ready[i] = adv && grant[i]`.
  - `req_ready` must not depend on `rsp_ready` other than through `adv`.
- **Pointer update:** on accept, `rr_ptr <= (grant_idx+1) mod NUM_REQS`, with explicit wrap from NUM_REQS-1 to 0. With no accept, `rr_ptr` holds.
- **Stage 1:** on `adv`, captures {accepted, a, b, idx, tag}. With no request, it captures valid=0 and the data is don't-care.
- **Multiplier:** one combinational instance operating on the stage-1 operands.
- **Stages 2..LATENCY:** carry {valid, y, idx, tag}; each loads from the previous stage on `adv`. With `LATENCY==1`, `rsp_y` comes combinationally from the stage-1 operands.
- **Response:** driven from the last stage.
- **Throughput:** one product per cycle while `rsp_ready=1`.
- **Ordering:** responses leave in acceptance order.
- **Arithmetic:** RNE rounding; exception flags are dropped. NaN, Inf and zero follow the multiplier unchanged.
- **`busy`:** OR of all stage valid bits.
- **`stall_cnt`:** increments while `rsp_valid && !rsp_ready` and holds at 0xFFFF_FFFF.
- **Reset:** asynchronous. `rr_ptr=0`, all stage valid bits 0, stage data 0, `stall_cnt=0`. Therefore `rsp_valid=0`, `busy=0`, `rsp_y=0`, `rsp_idx=0`, `rsp_tag=0` while reset is held.
  - Reset asserted mid-operation discards all in-flight entries with no responses.
  - `req_ready` equals the combinational grant, since `adv=1` after reset.
- **Simultaneous events:** when the last stage drains (`rsp_ready=1`) in the same cycle a new request is accepted, both occur.

## Timing
- **Latency:** request accepted at edge N gives `rsp_valid` after edge N+LATENCY-1, i.e. visible in cycle N+LATENCY-1 relative to the accept cycle N. For LATENCY=1, the response appears in the cycle after the accept.
- **Backpressure:** a stall freezes every stage and `rr_ptr`, and drops all `req_ready` in that same cycle. Response outputs stay stable while stalled.
- **Arbitration:** purely combinational from `req_valid` and `rr_ptr`. There are no combinational paths from `req_*` to `rsp_*`.

## Structure
- **Shared package `vx_tcu_bhf_pkg`:** FP16/FP32 recoded width constants (16, 33) and the stage struct type {valid, idx, tag, y}.
- **Sub-module `vx_tcu_bhf_rr_arb`:** parameterized round-robin priority picker (`req_valid`, `rr_ptr` → one-hot grant, grant index).
- **Pipeline:** one generate loop over the stages.

## Test plan
1. Reset release with all `req_valid=0` → `rsp_valid=0`, `busy=0`, `stall_cnt=0`, `req_ready=0`.
2. Requester 2 sends a=0x3C00, b=0x4000, tag=0x5A, LATENCY=2 → exactly one response one cycle after accept with `rsp_y=0x080800000`, `rsp_idx=2`, `rsp_tag=0x5A`.
3. All 4 requesters held valid continuously (`rsp_ready=1`) → grants 0,1,2,3,0,… one per cycle; every index served once per 4 accepts.
4. Back-to-back 0x3E00×0x4000 then 0x3C00×0x3C00, with `rsp_ready=0` for 3 cycles → products held stable, `req_ready=0`, `stall_cnt=3`; then `0x080C00000` followed by `0x080000000`, in order.
5. 0x0000×0x4000 → `rsp_y` sign=0 and recoded exponent top bits 000, i.e. zero.
6. `reset_n` pulsed low with 2 entries in flight → `rsp_valid` drops immediately and no stale response appears after release.

Source files
------------

// File: rtl/vx_tcu_bhf_pkg.sv
// Shared widths and encodings for the TCU BHF multiply datapath.
// Recoded FP32 layout: {sign, exp[8:0], fract[22:0]}; exp top bits
// 000 = zero, 110 = infinity, 111 = NaN.
package vx_tcu_bhf_pkg;

    localparam int unsigned FP16_W     = 16;
    localparam int unsigned FP32_REC_W = 33;

    typedef logic [FP16_W-1:0]     fp16_t;
    typedef logic [FP32_REC_W-1:0] fp32_rec_t;

    localparam logic [8:0] REC_EXP_INF  = 9'h180;
    localparam logic [8:0] REC_EXP_NAN  = 9'h1C0;
    localparam fp32_rec_t  REC_NAN      = {1'b0, REC_EXP_NAN, 23'h40_0000};

    // Recoded exponent offset for an FP16 x FP16 product:
    // lead + ea + eb - 2*25 + 127 + 129 (FP32 bias plus recoding offset).
    localparam logic [8:0] REC_EXP_BASE = 9'd206;

endpackage

// File: rtl/VX_tcu_bhf_fp16mul.sv
// Combinational FP16 x FP16 -> recoded FP32 multiplier.
// The product of two FP16 values always fits exactly in FP32 (22-bit
// significand, exponent range well inside normal FP32), so no rounding
// step is needed and the RNE result equals the exact product.
// Ports: a, b - FP16 operands; y - recoded FP32 product.
module VX_tcu_bhf_fp16mul
    import vx_tcu_bhf_pkg::*;
(
    input  fp16_t     a,
    input  fp16_t     b,
    output fp32_rec_t y
);

    logic        a_exp_max, b_exp_max, a_exp_zero, b_exp_zero;
    logic        a_frac_zero, b_frac_zero;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        sign, res_nan, res_inf, res_zero;
    logic [10:0] ma, mb;
    logic [4:0]  ea_adj, eb_adj;
    logic [21:0] prod;
    logic [4:0]  lead, sh;
    logic [8:0]  exp_rec;
    logic [22:0] frac;

    // Operand classification
    assign a_exp_max   = &a[14:10];
    assign b_exp_max   = &b[14:10];
    assign a_exp_zero  = ~|a[14:10];
    assign b_exp_zero  = ~|b[14:10];
    assign a_frac_zero = ~|a[9:0];
    assign b_frac_zero = ~|b[9:0];
    assign a_nan       = a_exp_max & ~a_frac_zero;
    assign b_nan       = b_exp_max & ~b_frac_zero;
    assign a_inf       = a_exp_max & a_frac_zero;
    assign b_inf       = b_exp_max & b_frac_zero;
    assign a_zero      = a_exp_zero & a_frac_zero;
    assign b_zero      = b_exp_zero & b_frac_zero;

    assign sign     = a[15] ^ b[15];
    assign res_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign res_inf  = a_inf | b_inf;
    assign res_zero = a_zero | b_zero;

    // Subnormals use exponent 1 with no hidden bit
    assign ma     = {~a_exp_zero, a[9:0]};
    assign mb     = {~b_exp_zero, b[9:0]};
    assign ea_adj = a_exp_zero ? 5'd1 : a[14:10];
    assign eb_adj = b_exp_zero ? 5'd1 : b[14:10];
    assign prod   = 22'(ma) * 22'(mb);

    // Leading-one position of the raw product
    always_comb begin
        lead = '0;
        for (int i = 0; i < 22; i++) begin
            if (prod[i]) lead = 5'(i);
        end
    end

    // Hidden bit lands on bit 23 and falls off the 23-bit fraction
    assign sh      = 5'd23 - lead;
    assign frac    = {1'b0, prod} << sh;
    assign exp_rec = 9'(lead) + 9'(ea_adj) + 9'(eb_adj) + REC_EXP_BASE;

    always_comb begin
        y = {sign, exp_rec, frac};
        if (res_nan)       y = REC_NAN;
        else if (res_inf)  y = {sign, REC_EXP_INF, 23'd0};
        else if (res_zero) y = {sign, 32'd0};
    end

endmodule

// File: rtl/vx_tcu_bhf_rr_arb.sv
// Round-robin priority picker: first valid requester scanning cyclically
// from rr_ptr. Purely combinational.
// Ports: req_valid, rr_ptr in; grant (one-hot or zero), grant_idx out.
module vx_tcu_bhf_rr_arb #(
    parameter  int unsigned NUM_REQS = 4,
    localparam int unsigned IDX_W    = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] req_valid,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx
);

    localparam int unsigned PW = IDX_W + 1;

    logic [PW-1:0] pos;
    logic          found;

    // pos = (rr_ptr + k) mod NUM_REQS; the sum stays below 2*NUM_REQS
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            pos = {1'b0, rr_ptr} + PW'(k);
            if (pos >= PW'(NUM_REQS)) pos = pos - PW'(NUM_REQS);
            if (!found && req_valid[pos[IDX_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = pos[IDX_W-1:0];
            end
        end
        grant[grant_idx] = found;
    end

endmodule

// File: rtl/vx_tcu_bhf_mul_arb.sv
// Shares one FP16 multiplier among NUM_REQS requesters: round-robin
// arbitration, fixed-latency globally-stalled pipeline, single tagged
// response port, busy flag and saturating stall counter.
// Ports: clk, reset_n; req_valid/req_a/req_b/req_tag in, req_ready out;
// rsp_valid/rsp_y/rsp_idx/rsp_tag out, rsp_ready in; busy, stall_cnt out.
module vx_tcu_bhf_mul_arb
    import vx_tcu_bhf_pkg::*;
#(
    parameter  int unsigned NUM_REQS  = 4,
    parameter  int unsigned TAG_WIDTH = 8,
    parameter  int unsigned LATENCY   = 2,
    localparam int unsigned IDX_W     = $clog2(NUM_REQS)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_REQS-1:0]                req_valid,
    input  logic [NUM_REQS-1:0][FP16_W-1:0]    req_a,
    input  logic [NUM_REQS-1:0][FP16_W-1:0]    req_b,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0] req_tag,
    output logic [NUM_REQS-1:0]                req_ready,
    output logic                               rsp_valid,
    output logic [FP32_REC_W-1:0]              rsp_y,
    output logic [IDX_W-1:0]                   rsp_idx,
    output logic [TAG_WIDTH-1:0]               rsp_tag,
    input  logic                               rsp_ready,
    output logic                               busy,
    output logic [31:0]                        stall_cnt
);

    typedef struct packed {
        logic                 valid;
        logic [IDX_W-1:0]     idx;
        logic [TAG_WIDTH-1:0] tag;
        fp16_t                a;
        fp16_t                b;
    } op_stage_t;

    typedef struct packed {
        logic                 valid;
        logic [IDX_W-1:0]     idx;
        logic [TAG_WIDTH-1:0] tag;
        fp32_rec_t            y;
    } res_stage_t;

    logic                adv, accept;
    logic [NUM_REQS-1:0] grant;
    logic [IDX_W-1:0]    grant_idx, rr_ptr;
    op_stage_t           s1_q;
    fp32_rec_t           mul_y;

    // Whole pipeline freezes while the response is held
    assign adv       = !(rsp_valid && !rsp_ready);
    assign req_ready = adv ? grant : '0;
    assign accept    = adv && (|grant);

    vx_tcu_bhf_rr_arb #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Round-robin pointer moves past the winner on accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
        end else if (adv) begin
            s1_q.valid <= accept;
            s1_q.idx   <= grant_idx;
            s1_q.tag   <= req_tag[grant_idx];
            s1_q.a     <= req_a[grant_idx];
            s1_q.b     <= req_b[grant_idx];
        end
    end

    VX_tcu_bhf_fp16mul u_mul (
        .a (s1_q.a),
        .b (s1_q.b),
        .y (mul_y)
    );

    // Result stages 2..LATENCY
    generate
        if (LATENCY == 1) begin : g_lat1
            assign rsp_valid = s1_q.valid;
            assign rsp_y     = mul_y;
            assign rsp_idx   = s1_q.idx;
            assign rsp_tag   = s1_q.tag;
            assign busy      = s1_q.valid;
        end else begin : g_pipe
            localparam int unsigned NS = LATENCY - 1;
            logic [NS-1:0] stg_v;

            for (genvar s = 0; s < NS; s++) begin : g_stage
                res_stage_t d, q;
                if (s == 0) begin : g_first
                    assign d = {s1_q.valid, s1_q.idx, s1_q.tag, mul_y};
                end else begin : g_next
                    assign d = g_stage[s-1].q;
                end
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) q <= '0;
                    else if (adv) q <= d;
                end
                assign stg_v[s] = q.valid;
            end

            assign rsp_valid = g_stage[NS-1].q.valid;
            assign rsp_y     = g_stage[NS-1].q.y;
            assign rsp_idx   = g_stage[NS-1].q.idx;
            assign rsp_tag   = g_stage[NS-1].q.tag;
            assign busy      = s1_q.valid | (|stg_v);
        end
    endgenerate

    // Saturating count of backpressured cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (rsp_valid && !rsp_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_vx_tcu_bhf_mul_arb.sv
// Bench for vx_tcu_bhf_mul_arb: directed and random stimulus, scoreboard
// filled at accept time from a real-arithmetic product model, monitor on
// the falling edge comparing responses, arbitration, busy and stall count.
module tb_vx_tcu_bhf_mul_arb;

    localparam int N     = 4;
    localparam int TW    = 8;
    localparam int LAT   = 2;
    localparam int IDX_W = $clog2(N);

    logic                    clk;
    logic                    reset_n;
    logic [N-1:0]            req_valid;
    logic [N-1:0][15:0]      req_a;
    logic [N-1:0][15:0]      req_b;
    logic [N-1:0][TW-1:0]    req_tag;
    logic [N-1:0]            req_ready;
    logic                    rsp_valid;
    logic [32:0]             rsp_y;
    logic [IDX_W-1:0]        rsp_idx;
    logic [TW-1:0]           rsp_tag;
    logic                    rsp_ready;
    logic                    busy;
    logic [31:0]             stall_cnt;

    vx_tcu_bhf_mul_arb #(
        .NUM_REQS  (N),
        .TAG_WIDTH (TW),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .rsp_idx   (rsp_idx),
        .rsp_tag   (rsp_tag),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [TW-1:0]    tag;
        logic [32:0]      y;
        int unsigned      acc_edge;
    } exp_t;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [TW-1:0]    tag;
        logic [32:0]      y;
    } rsp_t;

    exp_t        sb[$];
    rsp_t        got_q[$];
    int          acc_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          m_ptr    = 0;
    longint      m_stall  = 0;
    int unsigned adv_edges = 0;
    bit          prev_stall = 1'b0;
    logic [32:0] held_y;
    logic [IDX_W-1:0] held_idx;
    logic [TW-1:0]    held_tag;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Product as a real number, then re-encoded from its double image
    function automatic logic [32:0] model_mul(input logic [15:0] a, input logic [15:0] b);
        int     ea, eb, fa, fb, e64;
        bit     an, bn, ai, bi, az, bz, s;
        real    va, vb, p;
        logic [63:0] bits;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        s  = a[15] ^ b[15];
        an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
        ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
        az = (ea == 0) && (fa == 0);  bz = (eb == 0) && (fb == 0);
        if (an || bn || (ai && bz) || (bi && az)) return {1'b0, 9'h1C0, 23'h400000};
        if (ai || bi) return {s, 9'h180, 23'd0};
        if (az || bz) return {s, 32'd0};
        va = (ea == 0) ? real'(fa) * (2.0 ** real'(-24)) : real'(fa + 1024) * (2.0 ** real'(ea - 25));
        vb = (eb == 0) ? real'(fb) * (2.0 ** real'(-24)) : real'(fb + 1024) * (2.0 ** real'(eb - 25));
        p    = va * vb;
        bits = $realtobits(p);
        e64  = int'(bits[62:52]) - 1023 + 256;
        return {s, 9'(e64), 23'(bits >> 29)};
    endfunction

    function automatic logic [15:0] rand_fp16();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 7))
                0: return 16'h0000;
                1: return 16'h8000;
                2: return 16'h7C00;
                3: return 16'hFC00;
                4: return 16'h7E00;
                5: return 16'h0001;
                6: return 16'h03FF;
                default: return 16'h7BFF;
            endcase
        end
        return 16'($urandom);
    endfunction

    // Monitor: one pass per cycle on the falling edge
    always @(negedge clk) begin : mon
        int     g;
        int     j;
        bit     adv;
        logic [N-1:0] exp_rdy;
        exp_t   e;
        rsp_t   r;
        if (!reset_n) begin
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_rsp_y", 64'(rsp_y), 64'(0));
            chk("rst_rsp_idx", 64'(rsp_idx), 64'(0));
            chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
            chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
            sb.delete();
            m_ptr      = 0;
            m_stall    = 0;
            prev_stall = 1'b0;
        end else begin
            adv = !(rsp_valid && !rsp_ready);
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            chk("busy", 64'(busy), 64'(sb.size() != 0));
            if (prev_stall) begin
                chk("hold_valid", 64'(rsp_valid), 64'(1));
                chk("hold_y", 64'(rsp_y), 64'(held_y));
                chk("hold_idx", 64'(rsp_idx), 64'(held_idx));
                chk("hold_tag", 64'(rsp_tag), 64'(held_tag));
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    e = sb[0];
                    chk("rsp_idx", 64'(rsp_idx), 64'(e.idx));
                    chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                    chk("rsp_y", 64'(rsp_y), 64'(e.y));
                    chk("rsp_latency", 64'(adv_edges), 64'(e.acc_edge + LAT));
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        r.idx = rsp_idx; r.tag = rsp_tag; r.y = rsp_y;
                        got_q.push_back(r);
                    end
                end
            end
            g = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
            exp_rdy = '0;
            if (adv && g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (adv && g >= 0) begin
                e.idx      = IDX_W'(g);
                e.tag      = req_tag[g];
                e.y        = model_mul(req_a[g], req_b[g]);
                e.acc_edge = adv_edges;
                sb.push_back(e);
                acc_q.push_back(g);
                m_ptr = (g + 1) % N;
            end
            prev_stall = rsp_valid && !rsp_ready;
            if (prev_stall && m_stall < 64'hFFFF_FFFF) m_stall++;
            held_y = rsp_y; held_idx = rsp_idx; held_tag = rsp_tag;
            if (adv) adv_edges++;
        end
    end

    task automatic send(input int i, input logic [15:0] a, input logic [15:0] b, input logic [TW-1:0] t);
        bit done;
        done = 1'b0;
        req_valid[i] = 1'b1; req_a[i] = a; req_b[i] = b; req_tag[i] = t;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (req_ready[i]) done = 1'b1;
            @(posedge clk); #1;
        end
        req_valid[i] = 1'b0;
        chk("send_accept", 64'(done), 64'(1));
    endtask

    initial begin : stim
        logic [N-1:0] acc;
        reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        // Idle after reset
        @(negedge clk);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("t1_busy", 64'(busy), 64'(0));
        chk("t1_stall_cnt", 64'(stall_cnt), 64'(0));
        chk("t1_req_ready", 64'(req_ready), 64'(0));

        // All requesters held valid: strict rotation from 0
        @(posedge clk); #1;
        acc_q.delete();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b1; req_a[i] = 16'h3C00 + 16'(i); req_b[i] = 16'h4000; req_tag[i] = TW'(8'h10 + i);
        end
        repeat (8) @(posedge clk);
        #1 req_valid = '0;
        chk("t3_acc_count", 64'(acc_q.size()), 64'(8));
        for (int k = 0; k < 8 && k < acc_q.size(); k++) chk("t3_rr_order", 64'(acc_q[k]), 64'(k % N));
        repeat (5) @(posedge clk); #1;

        // Single request with known product
        got_q.delete();
        send(2, 16'h3C00, 16'h4000, 8'h5A);
        repeat (4) @(posedge clk); #1;
        chk("t2_count", 64'(got_q.size()), 64'(1));
        if (got_q.size() >= 1) begin
            chk("t2_y", 64'(got_q[0].y), 64'(33'h080800000));
            chk("t2_idx", 64'(got_q[0].idx), 64'(2));
            chk("t2_tag", 64'(got_q[0].tag), 64'(8'h5A));
        end

        // Back-to-back pair under three cycles of backpressure
        got_q.delete();
        rsp_ready = 1'b0;
        send(0, 16'h3E00, 16'h4000, 8'hA1);
        send(0, 16'h3C00, 16'h3C00, 8'hA2);
        req_valid = '1;
        @(negedge clk);
        chk("t4_ready_stalled", 64'(req_ready), 64'(0));
        @(posedge clk); #1 req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_stall_cnt", 64'(stall_cnt), 64'(3));
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("t4_count", 64'(got_q.size()), 64'(2));
        if (got_q.size() >= 2) begin
            chk("t4_first_y", 64'(got_q[0].y), 64'(33'h080C00000));
            chk("t4_second_y", 64'(got_q[1].y), 64'(33'h080000000));
        end

        // Zero operand
        got_q.delete();
        send(1, 16'h0000, 16'h4000, 8'h33);
        repeat (4) @(posedge clk); #1;
        chk("t5_count", 64'(got_q.size()), 64'(1));
        if (got_q.size() >= 1) begin
            chk("t5_sign", 64'(got_q[0].y[32]), 64'(0));
            chk("t5_exp_top", 64'(got_q[0].y[31:29]), 64'(0));
        end

        // Reset with two entries in flight
        rsp_ready = 1'b0;
        send(1, 16'h3C00, 16'h3C00, 8'h01);
        send(3, 16'h4000, 16'h4000, 8'h02);
        got_q.delete();
        reset_n = 1'b0;
        #1;
        chk("t6_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        chk("t6_no_stale", 64'(got_q.size()), 64'(0));

        // Random traffic with random backpressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        req_valid[i] = 1'b1;
                        req_a[i]     = rand_fp16();
                        req_b[i]     = rand_fp16();
                        req_tag[i]   = TW'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
        end

        // Drain
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk); #1;
        chk("drain_empty", 64'(sb.size()), 64'(0));
        chk("drain_busy", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
